// File: rtl/pdh_pkg.sv
// pdh_pkg: shared types and PS word field positions for the PDH DAC controller.
//   cmd_t    - command codes carried in the PS word cmd field
//   state_t  - command sequencer states
//   field localparams for the PS->PL word and the PL->PS callback word
package pdh_pkg;

   typedef enum logic [3:0] {
      CMD_IDLE     = 4'd0,
      CMD_SET_LED  = 4'd1,
      CMD_SET_DAC  = 4'd2,
      CMD_SET_SLEW = 4'd3,
      CMD_GET_DAC  = 4'd4
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // PS -> PL word
   localparam int SRST_BIT = 31;
   localparam int STB_BIT  = 30;
   localparam int CMD_MSB  = 29;
   localparam int CMD_LSB  = 26;
   localparam int CH_MSB   = 17;
   localparam int CH_LSB   = 14;
   // only data[17:0] carries meaning for any command
   localparam int DATA_KEEP = 18;

   // PL -> PS callback word
   localparam int RSP_CMD_LSB = 28;
   localparam int RSP_ERR_BIT = 27;
   localparam int PAYLOAD_W   = 27;

endpackage

// File: rtl/pdh_slew_ch.sv
// pdh_slew_ch: one DAC channel - holds target, slew step and output code and
// moves the output toward the target by at most one step per cycle.
//   clk, rst_n   clock / async active-low reset
//   srst_i       synchronous soft reset
//   tgt_we_i     load tgt_i as new target
//   step_we_i    load step_i as new slew step (0 = jump in one cycle)
//   dat_o        current output code (two's complement)
//   busy_o       output differs from target
//   chg_o        registered flag: output changed on the last clock edge
module pdh_slew_ch #(
   parameter int DAC_W  = 14,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              srst_i,
   input  logic              tgt_we_i,
   input  logic              step_we_i,
   input  logic [DAC_W-1:0]  tgt_i,
   input  logic [STEP_W-1:0] step_i,
   output logic [DAC_W-1:0]  dat_o,
   output logic              busy_o,
   output logic              chg_o
);

   // wide enough to hold target-output without overflow and any step value
   localparam int CW = ((DAC_W > STEP_W) ? DAC_W : STEP_W) + 2;

   logic [DAC_W-1:0]  tgt_q, tgt_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [DAC_W-1:0]  out_q, out_d;
   logic              chg_q, chg_d;
   logic signed [CW-1:0] t_s, o_s, step_s, diff_s, mag_s;

   // next target/step/output: signed distance decides direction, and the
   // final partial step lands exactly on target so there is no overshoot
   always_comb begin
      tgt_d  = tgt_q;
      step_d = step_q;
      if (tgt_we_i) begin
         tgt_d = tgt_i;
      end else begin
         tgt_d = tgt_q;
      end
      if (step_we_i) begin
         step_d = step_i;
      end else begin
         step_d = step_q;
      end
      t_s    = {{(CW-DAC_W){tgt_q[DAC_W-1]}}, tgt_q};
      o_s    = {{(CW-DAC_W){out_q[DAC_W-1]}}, out_q};
      step_s = {{(CW-STEP_W){1'b0}}, step_q};
      diff_s = t_s - o_s;
      if (diff_s[CW-1]) begin
         mag_s = -diff_s;
      end else begin
         mag_s = diff_s;
      end
      if ((step_q == {STEP_W{1'b0}}) || (mag_s <= step_s)) begin
         out_d = tgt_q;
      end else if (!diff_s[CW-1]) begin
         out_d = out_q + DAC_W'(step_q);
      end else begin
         out_d = out_q - DAC_W'(step_q);
      end
      chg_d = (out_d != out_q);
   end

   // channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_q  <= {DAC_W{1'b0}};
         step_q <= {STEP_W{1'b0}};
         out_q  <= {DAC_W{1'b0}};
         chg_q  <= 1'b0;
      end else if (srst_i) begin
         tgt_q  <= {DAC_W{1'b0}};
         step_q <= {STEP_W{1'b0}};
         out_q  <= {DAC_W{1'b0}};
         chg_q  <= 1'b0;
      end else begin
         tgt_q  <= tgt_d;
         step_q <= step_d;
         out_q  <= out_d;
         chg_q  <= chg_d;
      end
   end

   assign dat_o  = out_q;
   assign busy_o = (tgt_q != out_q);
   assign chg_o  = chg_q;

endmodule

// File: rtl/pdh_dac_ctrl.sv
// pdh_dac_ctrl: PS-commanded DAC controller with per-channel slew limiting.
//   clk, rst_n      clock / async active-low reset
//   axi_from_ps_i   [31] soft reset, [30] strobe, [29:26] cmd, [25:0] data
//   axi_to_ps_o     [31:28] last cmd, [27] error, [26:0] payload
//   led_o           LED register
//   dac_dat_o       packed channel codes, channel k at [k*DAC_W +: DAC_W]
//   dac_wrt_o       one-cycle pulse in the cycle after any output change
//   busy_o          some channel has not yet reached its target
module pdh_dac_ctrl
   import pdh_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DAC_W  = 14,
   parameter int STEP_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             axi_from_ps_i,
   output logic [31:0]             axi_to_ps_o,
   output logic [7:0]              led_o,
   output logic [NUM_CH*DAC_W-1:0] dac_dat_o,
   output logic                    dac_wrt_o,
   output logic                    busy_o
);

   state_t                 state_q, state_d;
   logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [3:0]             cmd_q, cmd_d;
   logic [DATA_KEEP-1:0]   data_q, data_d;
   logic [7:0]             led_q, led_d;
   logic [31:0]            resp_q, resp_d;
   logic                   wrt_q, wrt_d;
   logic                   srst, stb_rise, ch_ok, valid, exec;
   logic [3:0]             ch;
   logic [DAC_W-1:0]       cur_code;
   logic [PAYLOAD_W-1:0]   payload;
   logic [NUM_CH-1:0]      tgt_we, step_we, busy_ch, chg_ch;
   logic [NUM_CH*DAC_W-1:0] dat_all;

   assign srst     = axi_from_ps_i[SRST_BIT];
   assign stb_rise = sync2_q & ~prev_q;
   assign ch       = data_q[CH_MSB:CH_LSB];
   assign ch_ok    = ({28'd0, ch} < 32'(NUM_CH));

   // command decode: validity, selected channel readback and response payload
   always_comb begin
      cur_code = {DAC_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch == 4'(k)) begin
            cur_code = dat_all[k*DAC_W +: DAC_W];
         end else begin
            cur_code = cur_code;
         end
      end
      valid   = 1'b0;
      payload = {PAYLOAD_W{1'b0}};
      case (cmd_q)
         CMD_IDLE: begin
            valid = 1'b1;
         end
         CMD_SET_LED: begin
            valid   = 1'b1;
            payload = {19'd0, led_q};
         end
         CMD_SET_DAC: begin
            valid   = ch_ok;
            payload = ch_ok ? PAYLOAD_W'({ch, data_q[DAC_W-1:0]}) : {PAYLOAD_W{1'b0}};
         end
         CMD_SET_SLEW: begin
            valid   = ch_ok;
            payload = ch_ok ? PAYLOAD_W'({ch, data_q[STEP_W-1:0]}) : {PAYLOAD_W{1'b0}};
         end
         CMD_GET_DAC: begin
            valid   = ch_ok;
            payload = ch_ok ? PAYLOAD_W'({ch, cur_code}) : {PAYLOAD_W{1'b0}};
         end
         default: begin
            valid   = 1'b0;
            payload = {PAYLOAD_W{1'b0}};
         end
      endcase
   end

   // sequencer next state, command capture, LED/response update, channel strobes
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      led_d   = led_q;
      resp_d  = resp_q;
      sync1_d = axi_from_ps_i[STB_BIT];
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      wrt_d   = |chg_ch;
      exec    = (state_q == ST_EXEC) && valid;
      for (int k = 0; k < NUM_CH; k++) begin
         tgt_we[k]  = exec && (cmd_q == CMD_SET_DAC)  && (ch == 4'(k));
         step_we[k] = exec && (cmd_q == CMD_SET_SLEW) && (ch == 4'(k));
      end
      case (state_q)
         ST_IDLE: begin
            // edges seen in EXEC/RESP are simply lost: prev_q still tracks them
            if (stb_rise) begin
               cmd_d   = axi_from_ps_i[CMD_MSB:CMD_LSB];
               data_d  = axi_from_ps_i[DATA_KEEP-1:0];
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (exec && (cmd_q == CMD_SET_LED)) begin
               led_d = data_q[7:0];
            end else begin
               led_d = led_q;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_d  = {cmd_q, ~valid, payload};
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // control registers; soft reset forces reset values and also holds the
   // strobe synchroniser clear so a strobe during soft reset is ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cmd_q   <= 4'd0;
         data_q  <= {DATA_KEEP{1'b0}};
         led_q   <= 8'd0;
         resp_q  <= 32'd0;
         wrt_q   <= 1'b0;
      end else if (srst) begin
         state_q <= ST_IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cmd_q   <= 4'd0;
         data_q  <= {DATA_KEEP{1'b0}};
         led_q   <= 8'd0;
         resp_q  <= 32'd0;
         wrt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         led_q   <= led_d;
         resp_q  <= resp_d;
         wrt_q   <= wrt_d;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pdh_slew_ch #(
         .DAC_W  (DAC_W),
         .STEP_W (STEP_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .srst_i    (srst),
         .tgt_we_i  (tgt_we[k]),
         .step_we_i (step_we[k]),
         .tgt_i     (data_q[DAC_W-1:0]),
         .step_i    (data_q[STEP_W-1:0]),
         .dat_o     (dat_all[k*DAC_W +: DAC_W]),
         .busy_o    (busy_ch[k]),
         .chg_o     (chg_ch[k])
      );
   end

   assign axi_to_ps_o = resp_q;
   assign led_o       = led_q;
   assign dac_dat_o   = dat_all;
   assign dac_wrt_o   = wrt_q;
   assign busy_o      = |busy_ch;

endmodule

// File: tb/tb_pdh_dac_ctrl.sv
module tb_pdh_dac_ctrl;
   import pdh_pkg::*;

   localparam int NUM_CH = 2;
   localparam int DAC_W  = 14;
   localparam int STEP_W = 8;

   typedef int iq_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] word;
   logic [31:0] axi_to_ps_o;
   logic [7:0]  led_o;
   logic [NUM_CH*DAC_W-1:0] dac_dat_o;
   logic        dac_wrt_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;
   int wrt_cnt = 0;
   logic [13:0] cap0[$];
   logic [13:0] cap1[$];
   logic        capb[$];
   int m_out[NUM_CH];

   pdh_dac_ctrl #(.NUM_CH(NUM_CH), .DAC_W(DAC_W), .STEP_W(STEP_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .axi_from_ps_i (word),
      .axi_to_ps_o   (axi_to_ps_o),
      .led_o         (led_o),
      .dac_dat_o     (dac_dat_o),
      .dac_wrt_o     (dac_wrt_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dac_wrt_o === 1'b1) wrt_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_start(input logic [3:0] c, input logic [25:0] d);
      word = {1'b0, 1'b0, c, d};
      cyc(6);
      word[30] = 1'b1;
      cyc(3);
      word[30] = 1'b0;
   endtask

   task automatic send(input logic [3:0] c, input logic [25:0] d);
      send_start(c, d);
      cyc(8);
   endtask

   task automatic capture(input int n);
      cap0.delete(); cap1.delete(); capb.delete();
      repeat (n) begin
         @(negedge clk);
         cap0.push_back(dac_dat_o[13:0]);
         cap1.push_back(dac_dat_o[27:14]);
         capb.push_back(busy_o);
      end
   endtask

   // successive distinct output values of one channel over the capture window
   function automatic void changes(input int ch, output iq_t r, output bit contig);
      int last, prev, v;
      r.delete();
      contig = 1'b1;
      last = -1;
      prev = (ch == 0) ? int'(cap0[0]) : int'(cap1[0]);
      for (int i = 1; i < cap0.size(); i++) begin
         v = (ch == 0) ? int'(cap0[i]) : int'(cap1[i]);
         if (v != prev) begin
            if (last >= 0 && i != last + 1) contig = 1'b0;
            last = i;
            r.push_back(v);
            prev = v;
         end
      end
   endfunction

   function automatic int sx(input int c);
      return (c >= 8192) ? c - 16384 : c;
   endfunction

   // expected output trajectory: move by step toward target, land on it when close
   function automatic iq_t model_seq(input int from, input int to, input int s);
      iq_t r;
      int o, t;
      o = sx(from);
      t = sx(to);
      while (o != t) begin
         if (s == 0 || (t - o <= s && o - t <= s)) o = t;
         else if (t > o) o = o + s;
         else o = o - s;
         r.push_back(o & 32'h3FFF);
      end
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      word = 32'd0;
      cyc(3);
      checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led_o); end
      checks++; if (axi_to_ps_o !== 32'd0) begin errors++; $display("FAIL reset_axi: got %h want 0", axi_to_ps_o); end
      checks++; if (dac_dat_o !== 28'd0) begin errors++; $display("FAIL reset_dat: got %h want 0", dac_dat_o); end
      checks++; if (dac_wrt_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_wrt_busy: got %b%b want 00", dac_wrt_o, busy_o); end
      rst_n = 1'b1;
      cyc(2);
      m_out[0] = 0; m_out[1] = 0;
   endtask

   task automatic test_set_led();
      send(CMD_SET_LED, 26'h55);
      checks++; if (led_o !== 8'h55) begin errors++; $display("FAIL set_led: got %h want 55", led_o); end
      checks++; if (axi_to_ps_o !== 32'h1000_0055) begin errors++; $display("FAIL set_led_resp: got %h want 10000055", axi_to_ps_o); end
   endtask

   task automatic test_set_dac_step0();
      logic [3:0]  chs[3]   = '{4'd0, 4'd1, 4'd0};
      logic [13:0] codes[3] = '{14'h0123, 14'h1ABC, 14'h0005};
      logic [27:0] exps[3]  = '{{14'h0000, 14'h0123}, {14'h1ABC, 14'h0123}, {14'h1ABC, 14'h0005}};
      logic [31:0] er;
      for (int i = 0; i < 3; i++) begin
         wrt_cnt = 0;
         send(CMD_SET_DAC, {8'd0, chs[i], codes[i]});
         er = {4'h2, 1'b0, 9'd0, chs[i], codes[i]};
         checks++; if (dac_dat_o !== exps[i]) begin errors++; $display("FAIL set_dac%0d: got %h want %h", i, dac_dat_o, exps[i]); end
         checks++; if (wrt_cnt != 1) begin errors++; $display("FAIL set_dac%0d_wrt: got %0d pulses want 1", i, wrt_cnt); end
         checks++; if (axi_to_ps_o !== er) begin errors++; $display("FAIL set_dac%0d_resp: got %h want %h", i, axi_to_ps_o, er); end
      end
      // same code again: nothing moves, so no write strobe
      wrt_cnt = 0;
      send(CMD_SET_DAC, {8'd0, 4'd0, 14'h0005});
      checks++; if (wrt_cnt != 0) begin errors++; $display("FAIL same_code_wrt: got %0d pulses want 0", wrt_cnt); end
   endtask

   task automatic test_soft_reset();
      word = {1'b1, 1'b1, 4'h1, 26'h0AA};
      cyc(5);
      checks++; if (led_o !== 8'h00 || dac_dat_o !== 28'd0 || axi_to_ps_o !== 32'd0 || busy_o !== 1'b0)
         begin errors++; $display("FAIL soft_reset: led=%h dat=%h axi=%h busy=%b want all 0", led_o, dac_dat_o, axi_to_ps_o, busy_o); end
      word = 32'd0;
      cyc(8);
      checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL soft_reset_strobe: led got %h want 00", led_o); end
      m_out[0] = 0; m_out[1] = 0;
   endtask

   task automatic test_slew();
      iq_t got;
      bit contig;
      int nb, bad;
      int e1[4] = '{16'h10, 16'h20, 16'h30, 16'h35};
      int e2[2] = '{16'h3FFE, 16'h3FFC};
      send(CMD_SET_SLEW, {8'd0, 4'd0, 6'd0, 8'h10});
      checks++; if (axi_to_ps_o !== {4'h3, 1'b0, 15'd0, 4'd0, 8'h10}) begin errors++; $display("FAIL set_slew_resp: got %h want 30000010", axi_to_ps_o); end
      wrt_cnt = 0;
      fork
         send(CMD_SET_DAC, {8'd0, 4'd0, 14'h0035});
         capture(30);
      join
      changes(0, got, contig);
      bad = (got.size() != 4) ? 0 : -1;
      for (int i = 0; i < 4 && bad < 0; i++) if (got[i] != e1[i]) bad = i;
      checks++; if (bad >= 0) begin errors++; $display("FAIL slew_seq: %0d values, idx %0d got %h want %h", got.size(), bad, (bad < got.size()) ? got[bad] : -1, e1[bad]); end
      checks++; if (!contig) begin errors++; $display("FAIL slew_contig: got gaps want consecutive"); end
      nb = 0;
      foreach (capb[i]) if (capb[i]) nb++;
      checks++; if (nb != 4) begin errors++; $display("FAIL slew_busy: got %0d cycles want 4", nb); end
      checks++; if (wrt_cnt != 4) begin errors++; $display("FAIL slew_wrt: got %0d pulses want 4", wrt_cnt); end
      // negative target near zero must not wrap through positive full scale
      send(CMD_SET_SLEW, {8'd0, 4'd0, 6'd0, 8'h04});
      send(CMD_SET_DAC, {8'd0, 4'd0, 14'h0002});
      cyc(20);
      checks++; if (dac_dat_o[13:0] !== 14'h0002) begin errors++; $display("FAIL slew_pre: got %h want 0002", dac_dat_o[13:0]); end
      fork
         send(CMD_SET_DAC, {8'd0, 4'd0, 14'h3FFC});
         capture(30);
      join
      changes(0, got, contig);
      bad = (got.size() != 2) ? 0 : -1;
      for (int i = 0; i < 2 && bad < 0; i++) if (got[i] != e2[i]) bad = i;
      checks++; if (bad >= 0 || !contig) begin errors++; $display("FAIL slew_neg: %0d values contig=%b, idx %0d want %h", got.size(), contig, bad, e2[(bad < 0) ? 0 : bad]); end
      m_out[0] = 16'h3FFC;
   endtask

   task automatic test_retarget();
      iq_t got;
      bit contig;
      int prev, mx, jump;
      send(CMD_SET_SLEW, {8'd0, 4'd1, 6'd0, 8'd2});
      fork
         begin
            send(CMD_SET_DAC, {8'd0, 4'd1, 14'd100});
            send(CMD_SET_DAC, {8'd0, 4'd1, 14'd20});
         end
         capture(90);
      join
      changes(1, got, contig);
      prev = 0; mx = 0; jump = 0;
      foreach (got[i]) begin
         if (got[i] - prev > 2 || prev - got[i] > 2) jump = 1;
         if (got[i] > mx) mx = got[i];
         prev = got[i];
      end
      checks++; if (cap1[cap1.size()-1] !== 14'd20) begin errors++; $display("FAIL retarget_final: got %0d want 20", cap1[cap1.size()-1]); end
      checks++; if (jump != 0 || !contig) begin errors++; $display("FAIL retarget_smooth: jump=%0d contig=%b want 0/1", jump, contig); end
      checks++; if (mx <= 20 || mx >= 100) begin errors++; $display("FAIL retarget_peak: got %0d want between 20 and 100", mx); end
      m_out[1] = 20;
   endtask

   task automatic test_errors();
      logic [27:0] save;
      logic [31:0] er;
      save = dac_dat_o;
      send(CMD_SET_DAC, {8'd0, 4'd5, 14'h0111});
      checks++; if (axi_to_ps_o !== 32'h2800_0000) begin errors++; $display("FAIL bad_ch_resp: got %h want 28000000", axi_to_ps_o); end
      checks++; if (dac_dat_o !== save) begin errors++; $display("FAIL bad_ch_dat: got %h want %h", dac_dat_o, save); end
      send(4'hF, 26'h3FF_FFFF);
      checks++; if (axi_to_ps_o !== 32'hF800_0000) begin errors++; $display("FAIL bad_cmd_resp: got %h want f8000000", axi_to_ps_o); end
      checks++; if (dac_dat_o !== save) begin errors++; $display("FAIL bad_cmd_dat: got %h want %h", dac_dat_o, save); end
      send(CMD_GET_DAC, {8'd0, 4'd1, 14'd0});
      er = {4'h4, 1'b0, 9'd0, 4'd1, 14'(m_out[1])};
      checks++; if (axi_to_ps_o !== er) begin errors++; $display("FAIL get_dac_resp: got %h want %h", axi_to_ps_o, er); end
   endtask

   task automatic test_held_strobe();
      word = {1'b0, 1'b0, 4'h1, 26'h3C};
      cyc(6);
      word[30] = 1'b1;
      cyc(10);
      word[7:0] = 8'hC3;
      cyc(10);
      word[30] = 1'b0;
      cyc(6);
      checks++; if (led_o !== 8'h3C) begin errors++; $display("FAIL held_strobe: led got %h want 3c", led_o); end
      checks++; if (axi_to_ps_o !== 32'h1000_003C) begin errors++; $display("FAIL held_strobe_resp: got %h want 1000003c", axi_to_ps_o); end
   endtask

   task automatic test_async_reset();
      bit found;
      send(CMD_SET_SLEW, {8'd0, 4'd0, 6'd0, 8'h10});
      send(CMD_SET_DAC, {8'd0, 4'd0, 14'h0000});
      send_start(CMD_SET_DAC, {8'd0, 4'd0, 14'h0035});
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (dac_dat_o[13:0] === 14'h0020) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL arst_reach: output got %h want to pass 0020", dac_dat_o[13:0]); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (dac_dat_o !== 28'd0 || busy_o !== 1'b0 || dac_wrt_o !== 1'b0)
         begin errors++; $display("FAIL arst_async: dat=%h busy=%b wrt=%b want 0", dac_dat_o, busy_o, dac_wrt_o); end
      wrt_cnt = 0;
      cyc(3);
      rst_n = 1'b1;
      cyc(4);
      checks++; if (wrt_cnt != 0 || dac_dat_o !== 28'd0) begin errors++; $display("FAIL arst_quiet: pulses=%0d dat=%h want 0", wrt_cnt, dac_dat_o); end
      send(CMD_SET_DAC, {8'd0, 4'd1, 14'h00AA});
      checks++; if (dac_dat_o !== {14'h00AA, 14'h0000}) begin errors++; $display("FAIL arst_after: got %h want %h", dac_dat_o, {14'h00AA, 14'h0000}); end
      m_out[0] = 0; m_out[1] = 16'hAA;
   endtask

   task automatic test_random();
      iq_t got, exp;
      bit contig;
      int bad, stp, tg[NUM_CH];
      logic [31:0] er;
      for (int it = 0; it < 4; it++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 255);
            send(CMD_SET_SLEW, {8'd0, 4'(c), 6'd0, 8'(stp)});
            tg[c] = $urandom_range(0, 16383);
            exp = model_seq(m_out[c], tg[c], stp);
            // stash expected for this channel in the queue slot order below
            if (c == 0) got = exp;
            else begin
               fork
                  begin
                     send(CMD_SET_DAC, {8'd0, 4'd0, 14'(tg[0])});
                     send(CMD_SET_DAC, {8'd0, 4'd1, 14'(tg[1])});
                  end
                  capture(1150);
               join
            end
         end
         exp = got;
         for (int c = 0; c < NUM_CH; c++) begin
            if (c == 1) exp = model_seq(m_out[1], tg[1], 0);
            changes(c, got, contig);
            if (c == 1) begin
               // recompute with the step actually programmed for ch1
               exp = model_seq(m_out[1], tg[1], int'(dut.g_ch[1].u_ch.step_q) * 0 + stp);
            end
            bad = (got.size() != exp.size()) ? 0 : -1;
            for (int i = 0; i < got.size() && bad < 0; i++) if (got[i] != exp[i]) bad = i;
            checks++; if (bad >= 0 || !contig) begin errors++; $display("FAIL rand%0d_ch%0d: %0d values want %0d, first bad idx %0d, contig=%b", it, c, got.size(), exp.size(), bad, contig); end
            m_out[c] = tg[c];
            send(CMD_GET_DAC, {8'd0, 4'(c), 14'd0});
            er = {4'h4, 1'b0, 9'd0, 4'(c), 14'(m_out[c])};
            checks++; if (axi_to_ps_o !== er) begin errors++; $display("FAIL rand%0d_get%0d: got %h want %h", it, c, axi_to_ps_o, er); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_led();
      test_set_dac_step0();
      test_soft_reset();
      test_slew();
      test_retarget();
      test_errors();
      test_held_strobe();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pdh_dac_ctrl.md
PDH_DAC_CTRL -- requirements
Module: pdh_dac_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2, number of DAC channels (1..16).
REQ-002 Parameter DAC_W, default 14, DAC code width, two's complement.
REQ-003 Parameter STEP_W, default 8, slew step width, unsigned.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 axi_from_ps_i  input  32  PS word: [31] soft reset, [30] strobe, [29:26] cmd, [25:0] data.
REQ-007 axi_to_ps_o  output  32  callback: [31:28] last cmd, [27] error, [26:0] payload.
REQ-008 led_o  output  8  LED register.
REQ-009 dac_dat_o  output  NUM_CH*DAC_W  packed channel outputs; channel k at [k*DAC_W +: DAC_W].
REQ-010 dac_wrt_o  output  1  one-cycle pulse, asserted the cycle after any dac_dat_o change.
REQ-011 busy_o  output  1  high while any channel output differs from its target.

Function
REQ-012 The block SHALL pass strobe through a 2-FF synchroniser and execute exactly one command per synchronised rising edge; held-high strobe SHALL NOT re-execute.
REQ-013 The block SHALL sample cmd/data on the same cycle the synchronised edge is detected; the PS holds them stable 5+ cycles before strobe.
REQ-014 FSM states IDLE -> EXEC (1 cycle) -> RESP (1 cycle) -> IDLE; edges arriving outside IDLE SHALL be dropped.
REQ-015 SET_LED (1): led_o <= data[7:0]; payload = {19'd0, led}.
REQ-016 SET_DAC (2): channel = data[17:14], code = data[13:0]; target[ch] <= code; payload = {ch, code}, zero-extended.
REQ-017 SET_SLEW (3): channel = data[17:14], step = data[STEP_W-1:0]; step[ch] <= step; payload = {ch, step}.
REQ-018 GET_DAC (4): no state change; payload = {ch, current dac code of ch}.
REQ-019 Channel index >= NUM_CH or unknown cmd SHALL set error=1, change no state, payload=0.
REQ-020 axi_to_ps_o SHALL update in RESP and hold until the next RESP; error clears on the next valid command.
REQ-021 Step 0: output SHALL equal target one cycle after target update.
REQ-022 Step>0: each cycle output moves toward target by step (signed compare); if |target-output| <= step, output SHALL equal target that cycle; no overshoot, no wrap.
REQ-023 New SET_DAC mid-slew SHALL retarget from the current output without a jump.
REQ-024 SET_SLEW mid-slew SHALL apply from the next cycle.
REQ-025 Channels SHALL slew independently and concurrently.
REQ-026 SET_DAC to a target equal to the output SHALL NOT pulse dac_wrt_o.

Reset
REQ-027 On rst_n low: led_o=0, dac_dat_o=0, all targets=0, all steps=0, axi_to_ps_o=0, dac_wrt_o=0, busy_o=0, FSM=IDLE, sync flops=0.
REQ-028 axi_from_ps_i[31]=1 SHALL act as synchronous reset to the same values while held, with strobe ignored.
REQ-029 Reset mid-slew SHALL force outputs to 0 immediately (async) with no dac_wrt_o pulse.

Structure
REQ-030 Package pdh_pkg SHALL hold cmd_t (CMD_IDLE=0, CMD_SET_LED=1, CMD_SET_DAC=2, CMD_SET_SLEW=3, CMD_GET_DAC=4) and word field bit positions.
REQ-031 Per-channel target/step/output and slew arithmetic SHALL live in sub-module pdh_slew_ch, instantiated NUM_CH times by generate.

Verification
REQ-032 Reset, SET_LED 0x55 -> led_o=0x55, axi_to_ps_o={4'h1,1'b0,19'd0,8'h55}.
REQ-033 SET_DAC ch0=0x0123, then ch1=0x1ABC, then ch0=0x0005 (step 0) -> dac_dat_o {0x0000,0x0123}, {0x1ABC,0x0123}, {0x1ABC,0x0005}; one dac_wrt_o pulse each.
REQ-034 SET_SLEW ch0 step=0x10, SET_DAC ch0=0x0035 from 0 -> outputs 0x10,0x20,0x30,0x35 on consecutive cycles; busy_o high 4 cycles.
REQ-035 Slew ch0 step=4 to 0x3FFC (-4) from 0x0002 -> 0x3FFE, 0x3FFC; no wrap through positive full-scale.
REQ-036 SET_DAC ch=5 with NUM_CH=2, then unknown cmd 0xF -> error=1, dac_dat_o unchanged; strobe held 20 cycles executes once.
REQ-037 rst_n pulse mid-slew at output 0x20 -> all outputs 0 asynchronously, busy_o=0, next SET_DAC accepted.
